// File: rtl/fft_frame_source.sv
// Frame streamer for the pipelined radix-2 FFT core: plays a loadable
// 2^N-entry complex sample RAM out as whole frames, with optional
// inter-frame gaps, multi-frame/continuous modes and a graceful stop.
module fft_frame_source #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 9,
    parameter int unsigned GAP_W = 8,
    parameter int unsigned FRM_W = 16
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             wr_en,
    input  logic [N-1:0]     wr_addr,
    input  logic [WIDTH-1:0] wr_re,
    input  logic [WIDTH-1:0] wr_im,
    output logic             wr_err,
    input  logic             start,
    input  logic             stop,
    input  logic [FRM_W-1:0] num_frames,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             real_only,
    output logic             dout_en,
    output logic [WIDTH-1:0] dout_re,
    output logic [WIDTH-1:0] dout_im,
    output logic [N-1:0]     dout_cnt,
    output logic             frame_sop,
    output logic             frame_eop,
    output logic [FRM_W-1:0] frames_sent,
    output logic             busy
);

    localparam int unsigned DEPTH     = 1 << N;
    localparam int unsigned RAM_W     = 2 * WIDTH;
    localparam logic [N-1:0] LAST_ADDR = N'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       addr_q, addr_d;
    logic [FRM_W-1:0]   frm_cnt_q, frm_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               stop_q, stop_d;
    logic [FRM_W-1:0]   num_frames_q;
    logic [GAP_W-1:0]   gap_len_q;
    logic               real_q;
    logic               latch_cfg;
    logic               issue;
    logic               last_frame;

    logic [RAM_W-1:0]   mem [DEPTH];
    logic [RAM_W-1:0]   rd_q;
    logic               rd_vld_q;
    logic [N-1:0]       rd_cnt_q;
    logic               wr_ok;

    assign wr_ok = wr_en && (state_q == S_IDLE);

    // Next-state, read-address sequencing, frame and gap counting
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        frm_cnt_d  = frm_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        stop_d     = stop_q;
        latch_cfg  = 1'b0;
        issue      = 1'b0;
        last_frame = 1'b0;
        case (state_q)
            S_IDLE: begin
                stop_d = 1'b0;
                if (start) begin
                    state_d   = S_RUN;
                    addr_d    = '0;
                    frm_cnt_d = '0;
                    latch_cfg = 1'b1;
                end
            end
            S_RUN: begin
                issue = 1'b1;
                if (stop) stop_d = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    last_frame = (num_frames_q != '0) &&
                                 (frm_cnt_q + FRM_W'(1) == num_frames_q);
                    frm_cnt_d  = frm_cnt_q + FRM_W'(1);
                    addr_d     = '0;
                    if (stop_q || stop || last_frame) begin
                        state_d = S_DRAIN;
                    end else if (gap_len_q == '0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                    end
                end else begin
                    addr_d = addr_q + N'(1);
                end
            end
            S_GAP: begin
                if (stop) stop_d = 1'b1;
                if (gap_cnt_q == gap_len_q - GAP_W'(1)) begin
                    state_d = S_RUN;
                    addr_d  = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            S_DRAIN: begin
                stop_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state, sequencing counters and start-time configuration
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            frm_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            stop_q       <= 1'b0;
            num_frames_q <= '0;
            gap_len_q    <= '0;
            real_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            frm_cnt_q <= frm_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            stop_q    <= stop_d;
            if (latch_cfg) begin
                num_frames_q <= num_frames;
                gap_len_q    <= gap_len;
                real_q       <= real_only;
            end
        end
    end

    // Sample RAM: write only while idle, registered read; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_addr] <= {wr_re, wr_im};
        rd_q <= mem[addr_q];
    end

    // Read-stage tag travelling alongside the RAM data
    always_ff @(posedge clk) begin
        if (areset) begin
            rd_vld_q <= 1'b0;
            rd_cnt_q <= '0;
        end else begin
            rd_vld_q <= issue;
            rd_cnt_q <= addr_q;
        end
    end

    // Output stage: zero everything between samples, apply real-only masking
    always_ff @(posedge clk) begin
        if (areset) begin
            dout_en     <= 1'b0;
            dout_re     <= '0;
            dout_im     <= '0;
            dout_cnt    <= '0;
            frame_sop   <= 1'b0;
            frame_eop   <= 1'b0;
            frames_sent <= '0;
            busy        <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            dout_en   <= rd_vld_q;
            dout_re   <= rd_vld_q ? rd_q[RAM_W-1:WIDTH] : '0;
            dout_im   <= (rd_vld_q && !real_q) ? rd_q[WIDTH-1:0] : '0;
            dout_cnt  <= rd_vld_q ? rd_cnt_q : '0;
            frame_sop <= rd_vld_q && (rd_cnt_q == '0);
            frame_eop <= rd_vld_q && (rd_cnt_q == LAST_ADDR);
            if (latch_cfg) begin
                frames_sent <= '0;
            end else if (frame_eop) begin
                frames_sent <= frames_sent + FRM_W'(1);
            end
            busy   <= (state_d != S_IDLE);
            wr_err <= wr_en && (state_q != S_IDLE);
        end
    end

endmodule

// File: tb/tb_fft_frame_source.sv
// Self-checking bench for fft_frame_source: a RAM image model plus a
// timeline model of which sample should appear on each cycle of a stream.
module tb_fft_frame_source;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned N     = 9;
    localparam int unsigned GAP_W = 8;
    localparam int unsigned FRM_W = 16;
    localparam int          DEPTH = 1 << N;

    logic             clk;
    logic             areset;
    logic             wr_en;
    logic [N-1:0]     wr_addr;
    logic [WIDTH-1:0] wr_re;
    logic [WIDTH-1:0] wr_im;
    logic             wr_err;
    logic             start;
    logic             stop;
    logic [FRM_W-1:0] num_frames;
    logic [GAP_W-1:0] gap_len;
    logic             real_only;
    logic             dout_en;
    logic [WIDTH-1:0] dout_re;
    logic [WIDTH-1:0] dout_im;
    logic [N-1:0]     dout_cnt;
    logic             frame_sop;
    logic             frame_eop;
    logic [FRM_W-1:0] frames_sent;
    logic             busy;

    logic [WIDTH-1:0] m_re [DEPTH];
    logic [WIDTH-1:0] m_im [DEPTH];

    int checks = 0;
    int errors = 0;

    fft_frame_source #(
        .WIDTH(WIDTH), .N(N), .GAP_W(GAP_W), .FRM_W(FRM_W)
    ) dut (
        .clk(clk), .areset(areset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_re(wr_re), .wr_im(wr_im),
        .wr_err(wr_err),
        .start(start), .stop(stop), .num_frames(num_frames),
        .gap_len(gap_len), .real_only(real_only),
        .dout_en(dout_en), .dout_re(dout_re), .dout_im(dout_im),
        .dout_cnt(dout_cnt), .frame_sop(frame_sop), .frame_eop(frame_eop),
        .frames_sent(frames_sent), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] out_now();
        return 64'({dout_en, dout_re, dout_im, dout_cnt, frame_sop, frame_eop});
    endfunction

    // Expected output tuple for cycle j after the start edge: frame f occupies
    // output cycles 2+f*P .. 2+f*P+DEPTH-1, where P is frame length plus gap.
    function automatic logic [63:0] exp_out(input int j, input int nfr, input int p, input bit ro);
        int o, f, s;
        logic [WIDTH-1:0] re, im;
        o = j - 2;
        if (o < 0) return 64'(0);
        f = o / p;
        s = o % p;
        if (f >= nfr || s >= DEPTH) return 64'(0);
        re = m_re[s];
        im = ro ? WIDTH'(0) : m_im[s];
        return 64'({1'b1, re, im, N'(s), (s == 0), (s == DEPTH - 1)});
    endfunction

    // Frames whose last sample appeared strictly before cycle j
    function automatic int exp_sent(input int j, input int nfr, input int p);
        int c;
        c = 0;
        for (int f = 0; f < nfr; f++)
            if (2 + f * p + DEPTH - 1 < j) c++;
        return c;
    endfunction

    task automatic write_word(input int a, input logic [WIDTH-1:0] re, input logic [WIDTH-1:0] im);
        wr_en   = 1'b1;
        wr_addr = N'(a);
        wr_re   = re;
        wr_im   = im;
        m_re[a] = re;
        m_im[a] = im;
        @(posedge clk); #1;
    endtask

    task automatic finish_load(input string name);
        wr_en = 1'b0;
        @(negedge clk);
        chk({name, " wr_err idle"}, 64'(wr_err), 64'(0));
        @(posedge clk); #1;
    endtask

    // Start a stream and check every output on every cycle until it settles.
    task automatic run_stream(input int nf, input int gap, input bit ro, input int stop_j,
                              input int wr_j, input int rst_j, input string name);
        int p, nfr, last, jend;
        bit dead;
        p    = DEPTH + gap;
        nfr  = (nf == 0) ? (stop_j / p + 1) : nf;
        last = 2 + (nfr - 1) * p + DEPTH - 1;
        jend = (rst_j >= 0) ? rst_j + 3 : last + 3;
        start      = 1'b1;
        num_frames = FRM_W'(nf);
        gap_len    = GAP_W'(gap);
        real_only  = ro;
        @(posedge clk); #1;
        start      = 1'b0;
        num_frames = FRM_W'($urandom);
        gap_len    = GAP_W'($urandom);
        real_only  = ~ro;
        for (int j = 0; j <= jend; j++) begin
            stop   = (j == stop_j);
            areset = (j == rst_j);
            wr_en  = (j == wr_j);
            if (j == wr_j) begin
                wr_addr = N'(5);
                wr_re   = WIDTH'($urandom);
                wr_im   = WIDTH'($urandom);
            end
            @(negedge clk);
            dead = (rst_j >= 0) && (j > rst_j);
            chk($sformatf("%s out j=%0d", name, j), out_now(),
                dead ? 64'(0) : exp_out(j, nfr, p, ro));
            chk($sformatf("%s busy j=%0d", name, j), 64'(busy),
                64'(!dead && (j < last)));
            chk($sformatf("%s frames_sent j=%0d", name, j), 64'(frames_sent),
                dead ? 64'(0) : 64'(exp_sent(j, nfr, p)));
            chk($sformatf("%s wr_err j=%0d", name, j), 64'(wr_err),
                64'(!dead && (wr_j >= 0) && (j == wr_j + 1)));
            @(posedge clk); #1;
        end
        stop   = 1'b0;
        areset = 1'b0;
        wr_en  = 1'b0;
    endtask

    initial begin
        areset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_re = '0; wr_im = '0;
        start = 1'b0; stop = 1'b0; num_frames = '0; gap_len = '0; real_only = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset out", out_now(), 64'(0));
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset frames_sent", 64'(frames_sent), 64'(0));
        chk("reset wr_err", 64'(wr_err), 64'(0));
        @(posedge clk); #1;
        areset = 1'b0;

        // Ramp image, single frame, back-to-back
        for (int i = 0; i < DEPTH; i++) write_word(i, WIDTH'(i), WIDTH'(-i));
        finish_load("ramp");
        run_stream(1, 0, 1'b0, -1, -1, -1, "single");

        // Random image, three frames with a 5-cycle gap
        for (int i = 0; i < DEPTH; i++) write_word(i, WIDTH'($urandom), WIDTH'($urandom));
        finish_load("rand");
        run_stream(3, 5, 1'b0, -1, -1, -1, "gap5");

        // Stop is ignored while idle; then continuous with stop mid-frame 2
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        @(negedge clk);
        chk("idle stop busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        run_stream(0, 0, 1'b0, 2 * DEPTH + int'($urandom_range(50, 450)), -1, -1, "cont_stop");

        // Continuous with random gap, stop pulsed inside the second frame
        begin
            int g;
            g = int'($urandom_range(1, 7));
            run_stream(0, g, 1'b0, (DEPTH + g) + int'($urandom_range(0, DEPTH - 1)), -1, -1,
                       "cont_gap_stop");
        end

        // Real-only mode with saturated imaginary image
        for (int i = 0; i < DEPTH; i++) write_word(i, WIDTH'($urandom), WIDTH'(16'h7FFF));
        finish_load("real");
        run_stream(2, int'($urandom_range(1, 9)), 1'b1, -1, -1, -1, "real_only");

        // Write to address 5 while streaming: dropped, flagged, RAM intact
        run_stream(2, 0, 1'b0, -1, 300, -1, "wr_busy");

        // Reset at sample 100 of a frame, then replay from sample 0
        run_stream(1, 0, 1'b0, -1, -1, 2 + 100, "mid_reset");
        run_stream(1, 0, 1'b0, -1, -1, -1, "replay");

        // Start coincident with reset: reset wins
        start = 1'b1; areset = 1'b1; num_frames = FRM_W'(1); gap_len = '0;
        @(posedge clk); #1;
        start = 1'b0; areset = 1'b0;
        @(negedge clk);
        chk("start_reset busy", 64'(busy), 64'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("start_reset out", out_now(), 64'(0));
        chk("start_reset busy late", 64'(busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
